dcache_sram_nway: RTL and testbench
===================================

// Module: dcache_sram_nway
// PURPOSE
//  N-way, byte-writable simple-dual-port data RAM for the D-cache, single clock domain.
//  Generalises the per-way DCACHE_SRAMx macros into one array:
//  - one write port targeting any subset of ways
//  - one read port returning all ways in parallel
//  - write-first same-address forwarding
//  - hardware clear sweep after reset or on flush
//  Sits between the D-cache controller (tag compare / way select) and the SRAM primitives.
// PARAMETERS
//  ADDR_WIDTH  9   entry address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32  bits per way per entry; must be a multiple of BYTE_SIZE
//  BYTE_SIZE   8   bits per byte-enable lane (8 or 9)
//  NUM_WAYS    2   number of ways (1..8)
//  OUTPUT_REG  0   1 = extra read output register; read latency 2 instead of 1
//  BE_WIDTH derived = DATA_WIDTH/BYTE_SIZE (localparam, not overridable)
// PORTS
//  clk         in   1                    single clock, all logic on posedge
//  rst         in   1                    synchronous, active-high reset
//  flush       in   1                    pulse: re-run clear sweep (ignored while init_busy)
//  init_busy   out  1                    1 while clear sweep in progress
//  wr_en       in   1                    write strobe
//  wr_way      in   NUM_WAYS             way mask; several bits = same data to several ways
//  wr_addr     in   ADDR_WIDTH           write entry
//  wr_data     in   DATA_WIDTH           write data
//  wr_byte_en  in   BE_WIDTH             per-lane write enable
//  rd_en       in   1                    read strobe
//  rd_addr     in   ADDR_WIDTH           read entry
//  rd_data     out  NUM_WAYS*DATA_WIDTH  way w at [w*DATA_WIDTH +: DATA_WIDTH]
//  rd_valid    out  1                    rd_data carries the result of an accepted read
// BEHAVIOUR
//  Reset (rst=1, sync):
//  - rd_data=0, rd_valid=0, init_busy=1, state=CLEAR, clr_addr=0
//  - any pipeline read in flight is dropped
//  FSM CLEAR:
//  - each cycle writes 0 to entry clr_addr in every way, all lanes; clr_addr++
//  - at clr_addr==2**ADDR_WIDTH-1: write it, go to RUN, init_busy->0 next cycle
//  - sweep = 2**ADDR_WIDTH cycles after rst deasserts
//  - wr_en/rd_en ignored; rd_valid=0
//  FSM RUN:
//  - normal access
//  - flush=1 -> CLEAR with clr_addr=0, init_busy=1 next cycle
//  - a write or read in the same cycle as flush still executes
//  Rst asserted mid-sweep or mid-read: restart from reset state; no partial result ever exposed.
//  Write (RUN, wr_en=1): for each way w with wr_way[w], each lane b with wr_byte_en[b]:
//  - mem[w][wr_addr] lane b <= wr_data lane b
//  - wr_way==0 or wr_byte_en==0 is a no-op
//  Read (RUN, rd_en=1):
//  - OUTPUT_REG=0: rd_data/rd_valid registered 1 cycle after rd_en
//  - OUTPUT_REG=1: registered 2 cycles after rd_en
//  - fully pipelined, one read per cycle
//  - rd_valid=1 only for cycles carrying a result
//  - rd_data holds its last value when no result arrives
//  Read-during-write, same cycle and rd_addr==wr_addr: write-first per lane per way.
//  - written lanes return new wr_data; unwritten lanes/ways return old contents
//  - different addresses: fully independent
//  Address wrap: no auto-increment in RUN; clr_addr does not wrap past max (FSM exits).
// STRUCTURE
//  Package dcache_pkg:
//  - typedef enum {CLEAR, RUN} for the FSM
//  - localparam function be_width(DATA_WIDTH, BYTE_SIZE)
//  Sub-module dcache_sram_bank: one way
//  - single-clock SDP array with byte enables and same-address write-first forwarding
//  - read latency 1
//  - instantiated NUM_WAYS times via generate
//  Top level holds:
//  - the clear FSM and clear-address counter
//  - write-port mux (clear vs. user)
//  - optional output register and rd_valid pipeline
// TESTING
//  T1 Reset/clear:
//  - rst 5 cycles, then idle -> init_busy=1 exactly 512 cycles after rst falls, then 0
//  - reads of addr 0, 255 and 511 return 0 in all ways
//  T2 Byte/way write (NUM_WAYS=2):
//  - wr way=2'b10 addr 0x1F data 0xA5A5A5A5 be=4'b0101, then read 0x1F
//  - rd_data way1=0x00A500A5, way0=0
//  - rd_valid 1 cycle after rd_en (OUTPUT_REG=0), 2 cycles (OUTPUT_REG=1)
//  T3 Read-during-write:
//  - preload addr 7 way0=0x11223344
//  - same cycle: write way0 addr 7 data 0xFFFFFFFF be=4'b1000 and read addr 7
//  - returns 0xFF223344
//  T4 Streaming: 512 back-to-back writes of descending data (0xFFFFFFFF down), then
//  512 back-to-back reads -> every word matches, rd_valid continuous 512 cycles.
//  T5 Flush mid-stream:
//  - flush during read burst -> reads accepted before flush complete
//  - init_busy high 512 cycles; subsequent reads return 0
//  T6 Reset mid-sweep:
//  - rst at sweep cycle 100 -> rd_valid stays 0
//  - sweep restarts from 0; full 512 cycles elapse before init_busy=0

Source files
------------

// File: rtl/dcache_sram_nway_pkg.sv
// dcache_sram_nway shared types: clear-FSM state and byte-lane helper.
// No ports; imported by the interface, the bank and the top.
package dcache_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int be_width(input int dw, input int bs);
    return dw / bs;
  endfunction

endpackage

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway bus: write port, read port, flush and init status.
// master = cache controller, slave = data RAM.
interface dcache_sram_nway_if
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int NUM_WAYS   = 2
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);

  logic                           flush;
  logic                           init_busy;
  logic                           wr_en;
  logic [NUM_WAYS-1:0]            wr_way;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [BE_WIDTH-1:0]            wr_byte_en;
  logic                           rd_en;
  logic [ADDR_WIDTH-1:0]          rd_addr;
  logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data;
  logic                           rd_valid;

  modport master (
    output flush, wr_en, wr_way, wr_addr, wr_data, wr_byte_en,
    output rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid
  );

  modport slave (
    input  flush, wr_en, wr_way, wr_addr, wr_data, wr_byte_en,
    input  rd_en, rd_addr,
    output init_busy, rd_data, rd_valid
  );

endinterface

// File: rtl/dcache_sram_nway_bank.sv
// dcache_sram_bank: one way, SDP byte-enable RAM, write-first forwarding.
// be_i=lane write enables, re_i=read strobe, rdata_o valid 1 cycle later.
module dcache_sram_bank
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  localparam int BE_WIDTH  = be_width(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fwd;
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be_i[b]) begin
        mem_q[waddr_i][b*BYTE_SIZE +: BYTE_SIZE] <=
          wdata_i[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  // same-address lanes being written return the new data
  always_comb begin
    fwd = mem_q[raddr_i];
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be_i[b] && (waddr_i == raddr_i)) begin
        fwd[b*BYTE_SIZE +: BYTE_SIZE] =
          wdata_i[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (re_i) begin
      rd_q <= fwd;
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way D-cache data RAM with clear sweep and flush.
// clk/rst plain ports; everything else on bus (slave modport).
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int NUM_WAYS   = 2,
  parameter int OUTPUT_REG = 0
) (
  input logic clk,
  input logic rst,
  dcache_sram_nway_if.slave bus
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           clr_q, clr_d;
  logic                            busy;
  logic                            clr_we;
  logic                            usr_we;
  logic                            rd_go;
  logic [ADDR_WIDTH-1:0]           w_addr;
  logic [DATA_WIDTH-1:0]           w_data;
  logic [BE_WIDTH-1:0]             w_be [NUM_WAYS];
  logic [NUM_WAYS*DATA_WIDTH-1:0]  bank_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_q == ADDR_MAX) state_d = RUN;
        else clr_d = clr_q + ADDR_WIDTH'(1);
      end
      RUN: begin
        if (bus.flush) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // clear sweep owns the write port; user access only in RUN
  always_comb begin
    busy   = (state_q == CLEAR);
    clr_we = busy && !rst;
    usr_we = !busy && !rst && bus.wr_en;
    rd_go  = !busy && !rst && bus.rd_en;
    w_addr = busy ? clr_q : bus.wr_addr;
    w_data = busy ? '0 : bus.wr_data;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_be[w] = '0;
      if (clr_we) w_be[w] = '1;
      else if (usr_we && bus.wr_way[w]) w_be[w] = bus.wr_byte_en;
    end
  end

  assign bus.init_busy = busy;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_sram_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .BYTE_SIZE (BYTE_SIZE)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .be_i   (w_be[w]),
      .waddr_i(w_addr),
      .wdata_i(w_data),
      .re_i   (rd_go),
      .raddr_i(bus.rd_addr),
      .rdata_o(bank_rd[w*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                           v1_q;
    logic                           vld_q;
    logic [NUM_WAYS*DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q  <= 1'b0;
        vld_q <= 1'b0;
        out_q <= '0;
      end else begin
        v1_q  <= rd_go;
        vld_q <= v1_q;
        if (v1_q) out_q <= bank_rd;
      end
    end

    assign bus.rd_valid = vld_q;
    assign bus.rd_data  = out_q;
  end else begin : g_noreg
    logic vld_q;

    always_ff @(posedge clk) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= rd_go;
    end

    assign bus.rd_valid = vld_q;
    assign bus.rd_data  = bank_rd;
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_dcache_sram_nway;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int BS    = 8;
  localparam int NW    = 2;
  localparam int OREG  = 0;
  localparam int LAT   = OREG + 1;
  localparam int DEPTH = 2**AW;
  localparam int BEW   = DW / BS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_sram_nway_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BYTE_SIZE(BS), .NUM_WAYS(NW)
  ) bus ();

  dcache_sram_nway #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS),
    .NUM_WAYS(NW), .OUTPUT_REG(OREG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural model: arrays + delay line; a sweep simply
  // zeroes the whole model (nothing is observable meanwhile)
  logic [DW-1:0]    m_mem [NW][DEPTH];
  bit               m_busy;
  int               m_left;
  bit               pv [LAT];
  logic [NW*DW-1:0] pd [LAT];
  logic [NW*DW-1:0] m_rd;
  bit               m_vld;
  bit               m_nv;
  logic [NW*DW-1:0] m_nd;
  bit               chk_en = 1'b0;

  task automatic m_zero();
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < DEPTH; a++) m_mem[w][a] = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b1;
      m_left = DEPTH;
      m_zero();
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0;
        pd[i] = '0;
      end
      m_rd  = '0;
      m_vld = 1'b0;
    end else begin
      m_nv = 1'b0;
      m_nd = '0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end else begin
        if (bus.wr_en)
          for (int w = 0; w < NW; w++)
            for (int b = 0; b < BEW; b++)
              if (bus.wr_way[w] && bus.wr_byte_en[b])
                m_mem[w][bus.wr_addr][b*BS +: BS] =
                  bus.wr_data[b*BS +: BS];
        if (bus.rd_en) begin
          m_nv = 1'b1;
          for (int w = 0; w < NW; w++)
            m_nd[w*DW +: DW] = m_mem[w][bus.rd_addr];
        end
        if (bus.flush) begin
          m_busy = 1'b1;
          m_left = DEPTH;
          m_zero();
        end
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = m_nv;
      pd[0] = m_nd;
      m_vld = pv[LAT-1];
      if (m_vld) m_rd = pd[LAT-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", 64'(bus.init_busy), 64'(m_busy));
      chk("m_vld", 64'(bus.rd_valid), 64'(m_vld));
      chk("m_data", bus.rd_data, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_way     = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_byte_en = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
  endtask

  task automatic wr(input logic [NW-1:0] way,
                    input logic [AW-1:0] addr,
                    input logic [DW-1:0] data,
                    input logic [BEW-1:0] be);
    bus.wr_en      = 1'b1;
    bus.wr_way     = way;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
    bus.wr_byte_en = be;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_one(input string tag,
                        input logic [AW-1:0] addr,
                        output logic [NW*DW-1:0] data);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early"}, 64'(bus.rd_valid), 64'd0);
      tick();
    end
    chk({tag, "_vld"}, 64'(bus.rd_valid), 64'd1);
    data = bus.rd_data;
  endtask

  task automatic wait_sweep(output int n, output bit vseen);
    n = 0;
    vseen = 1'b0;
    while (bus.init_busy && n < 2000) begin
      tick();
      n++;
      if (bus.rd_valid) vseen = 1'b1;
    end
  endtask

  logic [NW*DW-1:0] d;
  logic [DW-1:0]    e;
  int               n, vc, bc, first, last;
  bit               vs;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (4) tick();
    chk("rst_busy", 64'(bus.init_busy), 64'd1);
    chk("rst_vld", 64'(bus.rd_valid), 64'd0);
    chk("rst_data", bus.rd_data, 64'd0);
    rst = 1'b0;

    // T1: sweep length and cleared contents
    wait_sweep(n, vs);
    chk("t1_sweep", 64'(n), 64'd512);
    rd_one("t1_a0", 9'd0, d);
    chk("t1_d0", d, 64'd0);
    rd_one("t1_a255", 9'd255, d);
    chk("t1_d255", d, 64'd0);
    rd_one("t1_a511", 9'd511, d);
    chk("t1_d511", d, 64'd0);

    // T2: way and lane masking
    wr(2'b10, 9'h1F, 32'hA5A5A5A5, 4'b0101);
    rd_one("t2", 9'h1F, d);
    chk("t2_way1", 64'(d[63:32]), 64'h00A500A5);
    chk("t2_way0", 64'(d[31:0]), 64'd0);

    // T3: write-first forwarding on the same address
    wr(2'b01, 9'd7, 32'h11223344, 4'hF);
    bus.wr_en      = 1'b1;
    bus.wr_way     = 2'b01;
    bus.wr_addr    = 9'd7;
    bus.wr_data    = 32'hFFFFFFFF;
    bus.wr_byte_en = 4'b1000;
    rd_one("t3", 9'd7, d);
    idle();
    chk("t3_way0", 64'(d[31:0]), 64'hFF223344);

    // T4: streaming writes then streaming reads
    for (int i = 0; i < DEPTH; i++)
      wr(2'b11, AW'(i), 32'hFFFFFFFF - 32'(i), 4'hF);
    vc = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < DEPTH + LAT + 1; i++) begin
      bus.rd_en   = (i < DEPTH);
      bus.rd_addr = AW'(i);
      tick();
      if (bus.rd_valid) begin
        if (first < 0) first = i;
        last = i;
        e = 32'hFFFFFFFF - 32'(vc);
        if (bus.rd_data !== {e, e}) chk("t4_data", bus.rd_data, {e, e});
        vc++;
      end
    end
    bus.rd_en = 1'b0;
    chk("t4_cnt", 64'(vc), 64'd512);
    chk("t4_run", 64'(last - first + 1), 64'd512);

    // T5: flush during a read burst
    vc = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(i);
      bus.flush   = (i == 10);
      tick();
      if (bus.init_busy) bc++;
      if (bus.rd_valid) begin
        e = 32'hFFFFFFFF - 32'(vc);
        chk("t5_data", bus.rd_data, {e, e});
        vc++;
      end
    end
    idle();
    n = 0;
    while (bus.init_busy && n < 2000) begin
      tick();
      n++;
      if (bus.init_busy) bc++;
      if (bus.rd_valid) vc++;
    end
    chk("t5_reads", 64'(vc), 64'd11);
    chk("t5_busy", 64'(bc), 64'd512);
    rd_one("t5_post", 9'd5, d);
    chk("t5_zero", d, 64'd0);

    // T6: read dropped by reset, then reset mid-sweep
    bus.rd_en   = 1'b1;
    bus.rd_addr = 9'd3;
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    vs = bus.rd_valid;
    for (int i = 0; i < 100; i++) begin
      bus.rd_en   = 1'($urandom);
      bus.rd_addr = AW'($urandom);
      tick();
      if (bus.rd_valid) vs = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    wait_sweep(n, bc[0]);
    if (bc[0]) vs = 1'b1;
    chk("t6_vld", 64'(vs), 64'd0);
    chk("t6_sweep", 64'(n), 64'd512);

    // random traffic on a small address window
    for (int i = 0; i < 1500; i++) begin
      bus.wr_en      = 1'($urandom);
      bus.wr_way     = NW'($urandom);
      bus.wr_addr    = AW'($urandom_range(0, 15));
      bus.wr_data    = $urandom;
      bus.wr_byte_en = BEW'($urandom);
      bus.rd_en      = 1'($urandom);
      bus.rd_addr    = AW'($urandom_range(0, 15));
      bus.flush      = ($urandom_range(0, 399) == 0);
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
